weight_preload_dbuf: RTL

//  Parametrised, double-buffered weight preloader for the PE array. Streams ROWS lanes of WBITS-wide weights,
//  one tap per beat, into a shadow shift bank of depth TAPS. On swap, the full shadow bank is copied into the

---
 rtl/weight_preload_dbuf.sv | 125 ++++++++++++
 1 files changed

// File: rtl/weight_preload_dbuf.sv
`default_nettype none
// ============================================================================
//  Module   : weight_preload_dbuf
//  Purpose  : Double-buffered weight preloader. A shadow shift bank fills one
//             tap per beat while the active bank drives the PE array.
//  Revision : 1.0
// ============================================================================
module weight_preload_dbuf #(
    parameter int ROWS  = 5,
    parameter int TAPS  = 5,
    parameter int WBITS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ROWS*WBITS-1:0]          w_in,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic                           swap,
    input  logic                           clear,
    output logic [$clog2(TAPS+1)-1:0]      beat_cnt,
    output logic                           shadow_full,
    output logic                           swap_done,
    output logic                           active_valid,
    output logic                           swap_err,
    output logic [ROWS*TAPS*WBITS-1:0]     w_out
);

    localparam int                c_cnt_w     = $clog2(TAPS+1);
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(TAPS-1);

    generate
        if (TAPS < 1 || ROWS < 1 || WBITS < 1) begin : g_bad_params
            $error("weight_preload_dbuf: TAPS, ROWS and WBITS must all be >= 1");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [c_cnt_w-1:0]            r_cnt;
    logic [c_cnt_w-1:0]            w_cnt_nxt;
    logic [ROWS*TAPS*WBITS-1:0]    r_shadow;
    logic [ROWS*TAPS*WBITS-1:0]    r_active;
    logic                          r_swap_done;
    logic                          r_active_valid;
    logic                          r_swap_err;
    logic                          w_commit;
    logic                          w_shift;
    logic                          w_early_swap;

    // A commit only happens in FULL and a shift only in FILL, so they never collide.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_commit     = swap && (r_state == S_FULL);
        w_early_swap = swap && (r_state == S_FILL);
        w_shift      = w_valid && (r_state == S_FILL) && !clear;

        if (w_commit || clear) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_FILL;
        end else if (w_shift) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == c_last_beat) begin
                w_state_nxt = S_FULL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_FILL;
            r_cnt          <= '0;
            r_swap_done    <= 1'b0;
            r_active_valid <= 1'b0;
            r_swap_err     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_swap_done <= w_commit;
            if (w_commit) begin
                r_active_valid <= 1'b1;
            end
            if (w_early_swap) begin
                r_swap_err <= 1'b1;
            end
        end
    end

    // Each lane shifts toward tap 0; the newest beat always lands in tap TAPS-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_shift) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int t = 0; t < TAPS-1; t++) begin
                    r_shadow[(r*TAPS+t)*WBITS +: WBITS] <= r_shadow[(r*TAPS+t+1)*WBITS +: WBITS];
                end
                r_shadow[(r*TAPS+TAPS-1)*WBITS +: WBITS] <= w_in[r*WBITS +: WBITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
        end else if (w_commit) begin
            r_active <= r_shadow;
        end
    end

    assign w_ready      = (r_state == S_FILL);
    assign shadow_full  = (r_state == S_FULL);
    assign beat_cnt     = r_cnt;
    assign swap_done    = r_swap_done;
    assign active_valid = r_active_valid;
    assign swap_err     = r_swap_err;
    assign w_out        = r_active;

endmodule
`default_nettype wire
